// File: rtl/segment_capture.sv
// segment_capture: passive receiver for the multiplexed 3-digit 7-segment bus.
// Realigns select with segment, decodes active-low glyphs and decimal points,
// follows the blank/digit0/digit1/digit2 scan order and republishes the
// original 15-bit display word once per complete, error-free frame.
module segment_capture #(
    parameter int SEG_LAG = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  segment,
    input  logic [2:0]  select,
    output logic [14:0] data,
    output logic        valid,
    output logic        changed,
    output logic        err_code,
    output logic        err_seq,
    output logic [7:0]  frame_count
);

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        WAIT0 = 3'd1,
        D0    = 3'd2,
        D1    = 3'd3,
        D2    = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  sel_d;
    logic        is_digit;
    logic [1:0]  digit_idx;
    logic        glyph_ok;
    logic [3:0]  glyph_nib;
    logic        glyph_err;
    logic        seq_err;
    logic        commit;
    logic        start;
    logic        bad_frame;
    logic [14:0] shadow;

    // Select runs SEG_LAG cycles ahead of segment; delay it so both describe the same slot.
    generate
        if (SEG_LAG == 0) begin : g_nolag
            assign sel_d = select;
        end else begin : g_lag
            logic [SEG_LAG-1:0][2:0] sel_pipe;

            // Shift register aligning select with the segment data
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sel_pipe <= '0;
                end else begin
                    sel_pipe[0] <= select;
                    for (int i = 1; i < SEG_LAG; i++) sel_pipe[i] <= sel_pipe[i-1];
                end
            end

            assign sel_d = sel_pipe[SEG_LAG-1];
        end
    endgenerate

    // Classify the aligned slot: one of the three digit enables, or not a digit
    always_comb begin
        is_digit  = 1'b0;
        digit_idx = 2'd0;
        case (sel_d)
            3'b001: begin is_digit = 1'b1; digit_idx = 2'd0; end
            3'b010: begin is_digit = 1'b1; digit_idx = 2'd1; end
            3'b100: begin is_digit = 1'b1; digit_idx = 2'd2; end
            default: ;
        endcase
    end

    // Map the active-low glyph back to its hex value; anything else is unknown
    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (segment[6:0])
            7'h40: glyph_nib = 4'h0;
            7'h79: glyph_nib = 4'h1;
            7'h24: glyph_nib = 4'h2;
            7'h30: glyph_nib = 4'h3;
            7'h19: glyph_nib = 4'h4;
            7'h12: glyph_nib = 4'h5;
            7'h02: glyph_nib = 4'h6;
            7'h78: glyph_nib = 4'h7;
            7'h00: glyph_nib = 4'h8;
            7'h10: glyph_nib = 4'h9;
            7'h08: glyph_nib = 4'hA;
            7'h03: glyph_nib = 4'hB;
            7'h46: glyph_nib = 4'hC;
            7'h21: glyph_nib = 4'hD;
            7'h06: glyph_nib = 4'hE;
            7'h0E: glyph_nib = 4'hF;
            default: glyph_ok = 1'b0;
        endcase
    end

    assign glyph_err = is_digit && !glyph_ok;

    // Scan-order state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SYNC;
        else     state <= state_nx;
    end

    // Scan-order next state; any deviation drops back to SYNC with err_seq
    always_comb begin
        state_nx = state;
        seq_err  = 1'b0;
        commit   = 1'b0;
        start    = 1'b0;
        case (state)
            SYNC: begin
                if (sel_d == 3'b000) state_nx = WAIT0;
            end
            WAIT0: begin
                if (sel_d == 3'b001) begin
                    state_nx = D0;
                    start    = 1'b1;
                end else if (sel_d != 3'b000) begin
                    seq_err = 1'b1;
                end
            end
            D0: begin
                if (sel_d == 3'b010)      state_nx = D1;
                else if (sel_d != 3'b001) seq_err  = 1'b1;
            end
            D1: begin
                if (sel_d == 3'b100)      state_nx = D2;
                else if (sel_d != 3'b010) seq_err  = 1'b1;
            end
            D2: begin
                if (sel_d == 3'b000) begin
                    state_nx = WAIT0;
                    commit   = 1'b1;
                end else if (sel_d != 3'b100) begin
                    seq_err = 1'b1;
                end
            end
            default: seq_err = 1'b1;
        endcase
        if (seq_err) state_nx = SYNC;
    end

    // Shadow word: every digit-slot cycle overwrites its nibble and dp, last sample wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (seq_err) begin
            shadow <= '0;
        end else if (is_digit) begin
            if (glyph_ok) shadow[4*digit_idx +: 4] <= glyph_nib;
            shadow[12 + digit_idx] <= ~segment[7];
        end
    end

    // Bad-frame flag: set by any unknown glyph, cleared at frame start or at a dropped commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  bad_frame <= 1'b0;
        else if (glyph_err)       bad_frame <= 1'b1;
        else if (start || commit) bad_frame <= 1'b0;
    end

    // Publish the shadow word on a clean D2 -> blank edge and raise the status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data        <= '0;
            valid       <= 1'b0;
            changed     <= 1'b0;
            err_code    <= 1'b0;
            err_seq     <= 1'b0;
            frame_count <= '0;
        end else begin
            valid    <= 1'b0;
            changed  <= 1'b0;
            err_code <= glyph_err;
            err_seq  <= seq_err;
            if (commit && !bad_frame) begin
                data        <= shadow;
                valid       <= 1'b1;
                changed     <= (shadow != data);
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_segment_capture.sv
// Bench for segment_capture: drives the display-driver scan with a one-cycle
// segment lag and compares commits and error pulses against a frame-level model.
module tb_segment_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  segment;
    logic [2:0]  select;
    logic [14:0] data;
    logic        valid, changed, err_code, err_seq;
    logic [7:0]  frame_count;

    segment_capture #(.SEG_LAG(1)) dut (
        .clk(clk), .rst(rst), .segment(segment), .select(select),
        .data(data), .valid(valid), .changed(changed),
        .err_code(err_code), .err_seq(err_seq), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [6:0]  codes [16];
    logic [7:0]  pend;

    // observed events
    logic [14:0] got_data [$];
    logic        got_chg  [$];
    int          n_ecode = 0, n_eseq = 0, n_orphan = 0;

    // frame-level reference model
    logic [14:0] exp_data [$];
    logic        exp_chg  [$];
    logic [14:0] m_data;
    logic [7:0]  m_fc;

    // Collect pulses away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                got_data.push_back(data);
                got_chg.push_back(changed);
            end
            if (changed && !valid) n_orphan++;
            if (err_code) n_ecode++;
            if (err_seq)  n_eseq++;
        end
    end

    // Driver: select changes now, segment shows the glyph of the previous slot
    task automatic step(input logic [2:0] s, input logic [7:0] g);
        select  = s;
        segment = pend;
        pend    = g;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] enc(input logic [14:0] w, input int k);
        logic [3:0] nib;
        nib = w[4*k +: 4];
        return {~w[12+k], codes[nib]};
    endfunction

    function automatic logic [6:0] bad_pattern();
        logic [6:0] p;
        logic hit;
        do begin
            p = 7'($urandom);
            hit = 1'b0;
            for (int i = 0; i < 16; i++) if (codes[i] == p) hit = 1'b1;
        end while (hit);
        return p;
    endfunction

    // One full scan; bad_slot >= 0 replaces the last glyph of that slot with an unknown pattern
    task automatic send_frame(input logic [14:0] w, input int len, input int blank,
                              input int bad_slot);
        logic [7:0] g;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < len; c++) begin
                g = enc(w, k);
                if (k == bad_slot && c == len - 1) g = {g[7], bad_pattern()};
                step(3'(1 << k), g);
            end
        for (int b = 0; b < blank; b++) step(3'b000, 8'($urandom));
    endtask

    // Model: a clean frame from a synchronised receiver commits its word
    task automatic model_commit(input logic [14:0] w);
        exp_data.push_back(w);
        exp_chg.push_back(w != m_data);
        m_data = w;
        m_fc   = m_fc + 8'd1;
    endtask

    task automatic settle();
        repeat (4) step(3'b000, 8'hFF);
    endtask

    task automatic test_reset();
        checks++; if (data !== 15'h0)      $display("FAIL reset_data got=%h exp=0", data); else passes++;
        checks++; if (frame_count !== 8'h0) $display("FAIL reset_fc got=%0d exp=0", frame_count); else passes++;
        checks++; if ({valid, changed, err_code, err_seq} !== 4'b0)
            $display("FAIL reset_pulses got=%b exp=0000", {valid, changed, err_code, err_seq}); else passes++;
    endtask

    task automatic test_basic();
        step(3'b000, 8'hFF);
        send_frame(15'h5A3C, 1, 1, -1); model_commit(15'h5A3C);
        send_frame(15'h5A3C, 1, 1, -1); model_commit(15'h5A3C);
        settle();
        checks++; if (enc(15'h5A3C, 1) !== 8'hB0) $display("FAIL basic_enc got=%h exp=b0", enc(15'h5A3C, 1)); else passes++;
        checks++; if (got_data.size() !== exp_data.size())
            $display("FAIL basic_count got=%0d exp=%0d", got_data.size(), exp_data.size()); else passes++;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i] || got_chg[i] !== exp_chg[i])
                $display("FAIL basic_commit%0d got=%h/%b exp=%h/%b", i, got_data[i], got_chg[i], exp_data[i], exp_chg[i]);
            else passes++;
        end
        checks++; if (frame_count !== m_fc) $display("FAIL basic_fc got=%0d exp=%0d", frame_count, m_fc); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
    endtask

    task automatic test_change();
        send_frame(15'h7FFF, 2, 1, -1); model_commit(15'h7FFF);
        send_frame(15'h7FFF, 1, 2, -1); model_commit(15'h7FFF);
        settle();
        checks++; if (got_data.size() !== exp_data.size())
            $display("FAIL change_count got=%0d exp=%0d", got_data.size(), exp_data.size()); else passes++;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i] || got_chg[i] !== exp_chg[i])
                $display("FAIL change_commit%0d got=%h/%b exp=%h/%b", i, got_data[i], got_chg[i], exp_data[i], exp_chg[i]);
            else passes++;
        end
        checks++; if (n_orphan !== 0) $display("FAIL changed_without_valid got=%0d exp=0", n_orphan); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
    endtask

    task automatic test_glyph_err();
        int e0;
        e0 = n_ecode;
        send_frame(15'h1234, 1, 1, 1);
        settle();
        checks++; if (n_ecode - e0 !== 1) $display("FAIL glyph_err_pulses got=%0d exp=1", n_ecode - e0); else passes++;
        checks++; if (got_data.size() !== 0) $display("FAIL glyph_err_commit got=%0d exp=0", got_data.size()); else passes++;
        checks++; if (data !== m_data) $display("FAIL glyph_err_data got=%h exp=%h", data, m_data); else passes++;
        send_frame(15'h1234, 1, 1, -1); model_commit(15'h1234);
        settle();
        checks++; if (got_data.size() !== 1 || got_data[0] !== 15'h1234)
            $display("FAIL glyph_recover got_n=%0d data=%h exp=1234", got_data.size(), data); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
    endtask

    task automatic test_seq_skip();
        int s0;
        s0 = n_eseq;
        step(3'b001, enc(15'h0ABC, 0));
        step(3'b100, enc(15'h0ABC, 2));
        step(3'b000, 8'hFF);
        settle();
        checks++; if (n_eseq - s0 !== 1) $display("FAIL skip_err_seq got=%0d exp=1", n_eseq - s0); else passes++;
        checks++; if (got_data.size() !== 0) $display("FAIL skip_commit got=%0d exp=0", got_data.size()); else passes++;
        send_frame(15'h0ABC, 1, 1, -1); model_commit(15'h0ABC);
        settle();
        checks++; if (got_data.size() !== 1 || data !== 15'h0ABC)
            $display("FAIL skip_recover got_n=%0d data=%h exp=0abc", got_data.size(), data); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
    endtask

    task automatic test_bad_sel();
        int s0, e0;
        s0 = n_eseq; e0 = n_ecode;
        step(3'b001, enc(15'h2468, 0));
        step(3'b010, enc(15'h2468, 1));
        step(3'b011, 8'hFF);
        // still in SYNC, so a scan without a leading blank must not commit
        step(3'b001, enc(15'h2468, 0));
        step(3'b010, enc(15'h2468, 1));
        step(3'b100, enc(15'h2468, 2));
        step(3'b000, 8'hFF);
        settle();
        checks++; if (n_eseq - s0 !== 1) $display("FAIL badsel_err_seq got=%0d exp=1", n_eseq - s0); else passes++;
        checks++; if (n_ecode - e0 !== 0) $display("FAIL badsel_err_code got=%0d exp=0", n_ecode - e0); else passes++;
        checks++; if (got_data.size() !== 0) $display("FAIL badsel_commit got=%0d exp=0", got_data.size()); else passes++;
        checks++; if (frame_count !== m_fc) $display("FAIL badsel_fc got=%0d exp=%0d", frame_count, m_fc); else passes++;
        send_frame(15'h2468, 1, 1, -1); model_commit(15'h2468);
        settle();
        checks++; if (got_data.size() !== 1 || data !== 15'h2468)
            $display("FAIL badsel_recover got_n=%0d data=%h exp=2468", got_data.size(), data); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
    endtask

    task automatic test_random();
        int e0, exp_e;
        logic [14:0] w;
        int bad;
        e0 = n_ecode; exp_e = 0;
        for (int f = 0; f < 40; f++) begin
            w   = 15'($urandom);
            if (f % 7 == 3) w = m_data;
            bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
            send_frame(w, $urandom_range(1, 3), $urandom_range(1, 3), bad);
            if (bad < 0) model_commit(w);
            else exp_e++;
        end
        settle();
        checks++; if (got_data.size() !== exp_data.size())
            $display("FAIL rand_count got=%0d exp=%0d", got_data.size(), exp_data.size()); else passes++;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_data[i] || got_chg[i] !== exp_chg[i])
                $display("FAIL rand_commit%0d got=%h/%b exp=%h/%b", i, got_data[i], got_chg[i], exp_data[i], exp_chg[i]);
            else passes++;
        end
        checks++; if (n_ecode - e0 !== exp_e) $display("FAIL rand_err_code got=%0d exp=%0d", n_ecode - e0, exp_e); else passes++;
        checks++; if (frame_count !== m_fc) $display("FAIL rand_fc got=%0d exp=%0d", frame_count, m_fc); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
    endtask

    task automatic test_reset_mid();
        for (int f = 0; f < 3; f++) begin
            send_frame(15'h0100 + 15'(f), 1, 1, -1);
            model_commit(15'h0100 + 15'(f));
        end
        step(3'b001, enc(15'h6543, 0));
        step(3'b001, enc(15'h6543, 0));
        step(3'b010, enc(15'h6543, 1));
        step(3'b010, enc(15'h6543, 1));
        checks++; if (got_data.size() !== 3 || got_data[2] !== 15'h0102)
            $display("FAIL premid_commits got_n=%0d data=%h exp=0102", got_data.size(), data); else passes++;
        rst = 1'b1;
        #1;
        checks++; if (data !== 15'h0 || frame_count !== 8'h0)
            $display("FAIL midrst_state got=%h/%0d exp=0/0", data, frame_count); else passes++;
        checks++; if ({valid, changed, err_code, err_seq} !== 4'b0)
            $display("FAIL midrst_pulses got=%b exp=0000", {valid, changed, err_code, err_seq}); else passes++;
        got_data.delete(); got_chg.delete(); exp_data.delete(); exp_chg.delete();
        m_data = '0; m_fc = '0;
        select = 3'b010; pend = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0;
        step(3'b000, 8'hFF);
        send_frame(15'h6543, 1, 1, -1); model_commit(15'h6543);
        settle();
        checks++; if (got_data.size() !== 1 || data !== 15'h6543 || got_chg[0] !== 1'b1)
            $display("FAIL midrst_recover got_n=%0d data=%h exp=6543 changed", got_data.size(), data); else passes++;
        checks++; if (frame_count !== 8'd1) $display("FAIL midrst_fc got=%0d exp=1", frame_count); else passes++;
    endtask

    initial begin
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_data = '0; m_fc = '0;
        rst = 1'b1; select = 3'b000; segment = 8'hFF; pend = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic();
        test_change();
        test_glyph_err();
        test_seq_skip();
        test_bad_sel();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
